// File: rtl/audio_play_feeder_if.sv
// Write-side and transmitter-side signals of the stereo playback feeder.
// The master drives PCM words and transmitter timing; the slave is the feeder itself.
interface audio_play_feeder_if #(
    parameter int AW = 6
);
    logic          AC_LRC;
    logic          tx_done;
    logic          wr_en;
    logic [15:0]   wr_data;
    logic          full;
    logic [AW:0]   level;
    logic [3:0]    vol_shift;
    logic [15:0]   dac_data;
    logic          playing;
    logic          underrun;
    logic          overflow;
    logic          clr_flags;

    modport master (
        output AC_LRC, tx_done, wr_en, wr_data, vol_shift, clr_flags,
        input  full, level, dac_data, playing, underrun, overflow
    );

    modport slave (
        input  AC_LRC, tx_done, wr_en, wr_data, vol_shift, clr_flags,
        output full, level, dac_data, playing, underrun, overflow
    );
endinterface

// File: rtl/audio_play_feeder.sv
// Stereo sample FIFO feeding the codec transmitter; dac_data lands one cycle after tx_done.
// Writes while full are dropped and flagged; starvation at a pair boundary inserts silence and refills.
module audio_play_feeder #(
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int PREFILL = 8
) (
    input  logic              AC_BCLK,
    input  logic              reset,
    audio_play_feeder_if.slave bus
);

    typedef enum logic [1:0] {FILL, ALIGN, PLAY} state_t;

    localparam logic [AW:0] FULL_LVL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] PREFILL_LVL = (AW+1)'(PREFILL);
    localparam logic [AW:0] PAIR_LVL    = (AW+1)'(2);

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          tx_done_q;
    logic          tx_pulse;
    logic          pop;
    logic          push;
    logic          full;
    logic          zero_out;
    logic          underrun_set;
    logic          overflow_set;
    logic [15:0]   rd_word;
    logic [15:0]   scaled;
    logic [15:0]   dac_data;
    logic          underrun;
    logic          overflow;

    // Only the first cycle of a tx_done pulse counts.
    assign tx_pulse     = bus.tx_done & ~tx_done_q;
    assign full         = (level == FULL_LVL);
    // A pop frees a slot in the same cycle, so a write while full is still accepted then.
    assign push         = bus.wr_en & (~full | pop);
    assign overflow_set = bus.wr_en & full & ~pop;
    assign rd_word      = mem[rd_ptr];
    assign scaled       = $signed(rd_word) >>> bus.vol_shift;

    always_ff @(posedge AC_BCLK) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        zero_out     = 1'b0;
        underrun_set = 1'b0;
        case (state)
            FILL: begin
                zero_out = tx_pulse;
                if (level >= PREFILL_LVL) begin
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                // Start only at a pair boundary so the first word lands in the left slot.
                if (tx_pulse && bus.AC_LRC) begin
                    pop       = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (tx_pulse) begin
                    if (!bus.AC_LRC || level >= PAIR_LVL) begin
                        pop = 1'b1;
                    end else begin
                        zero_out     = 1'b1;
                        underrun_set = 1'b1;
                        state_nxt    = FILL;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge AC_BCLK) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge AC_BCLK) begin
        if (reset) begin
            tx_done_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            dac_data  <= '0;
            underrun  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tx_done_q <= bus.tx_done;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop) begin
                dac_data <= scaled;
            end else if (zero_out) begin
                dac_data <= '0;
            end
            // Clear beats a same-cycle set.
            underrun <= bus.clr_flags ? 1'b0 : (underrun | underrun_set);
            overflow <= bus.clr_flags ? 1'b0 : (overflow | overflow_set);
        end
    end

    assign bus.full     = full;
    assign bus.level    = level;
    assign bus.dac_data = dac_data;
    assign bus.playing  = (state == PLAY);
    assign bus.underrun = underrun;
    assign bus.overflow = overflow;

endmodule

// File: tb/tb_audio_play_feeder.sv
// Randomized and directed bench for audio_play_feeder against a queue-based playback model.
module tb_audio_play_feeder;

    localparam int DEPTH   = 64;
    localparam int AW      = 6;
    localparam int PREFILL = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    audio_play_feeder_if #(.AW(AW)) bus ();

    audio_play_feeder #(.DEPTH(DEPTH), .AW(AW), .PREFILL(PREFILL)) dut (
        .AC_BCLK (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a word queue plus the playback mode (0 fill, 1 align, 2 play).
    logic [15:0] q[$];
    int          m_mode = 0;
    logic [15:0] m_dac = '0;
    bit          m_ur = 0;
    bit          m_ov = 0;
    bit          m_prev_tx = 0;
    bit          m_last_pop = 0;
    logic [15:0] m_last_word = '0;

    // Transmitter timing: 16-cycle slots, tx_done near the end of each slot.
    int          slot_cyc = 0;
    bit          lrc_r = 0;
    bit          wide = 0;
    bit          auto_tx = 1;
    bit          rand_wide = 0;
    bit          auto_refill = 0;
    logic [15:0] refill_word = 16'h6000;
    int          refill_hits = 0;

    function automatic logic [15:0] attenuate(input logic [15:0] s, input logic [3:0] v);
        logic signed [31:0] t;
        t = {{16{s[15]}}, s};
        t = t >>> v;
        return t[15:0];
    endfunction

    function automatic bit will_pop();
        bit pulse;
        pulse = bus.tx_done && !m_prev_tx && !reset;
        return pulse && ((m_mode == 1 && bus.AC_LRC) ||
                         (m_mode == 2 && (!bus.AC_LRC || q.size() >= 2)));
    endfunction

    task automatic model_step();
        bit pulse;
        bit pop;
        bit ur_set;
        bit ov_set;
        int old_size;
        logic [15:0] w;
        m_last_pop = 0;
        if (reset) begin
            q.delete();
            m_mode = 0;
            m_dac = '0;
            m_ur = 0;
            m_ov = 0;
            m_prev_tx = 0;
            return;
        end
        pulse = bus.tx_done && !m_prev_tx;
        m_prev_tx = bus.tx_done;
        pop = 0;
        ur_set = 0;
        ov_set = 0;
        old_size = q.size();
        case (m_mode)
            0: begin
                if (pulse) m_dac = '0;
                if (old_size >= PREFILL) m_mode = 1;
            end
            1: begin
                if (pulse && bus.AC_LRC) begin
                    pop = 1;
                    m_mode = 2;
                end
            end
            default: begin
                if (pulse) begin
                    if (!bus.AC_LRC || old_size >= 2) begin
                        pop = 1;
                    end else begin
                        m_dac = '0;
                        ur_set = 1;
                        m_mode = 0;
                    end
                end
            end
        endcase
        if (pop) begin
            if (q.size() == 0) begin
                check("model_right_word_present", 0, 1);
            end else begin
                w = q.pop_front();
                m_dac = attenuate(w, bus.vol_shift);
                m_last_pop = 1;
                m_last_word = w;
            end
        end
        if (bus.wr_en) begin
            if (old_size < DEPTH || pop) q.push_back(bus.wr_data);
            else ov_set = 1;
        end
        m_ur = bus.clr_flags ? 0 : (m_ur | ur_set);
        m_ov = bus.clr_flags ? 0 : (m_ov | ov_set);
    endtask

    task automatic compare_all();
        check("dac_data", bus.dac_data, m_dac);
        check("level", bus.level, q.size());
        check("full", bus.full, q.size() == DEPTH);
        check("playing", bus.playing, m_mode == 2);
        check("underrun", bus.underrun, m_ur);
        check("overflow", bus.overflow, m_ov);
    endtask

    task automatic cycle();
        if (slot_cyc == 0) wide = rand_wide && ($urandom_range(0, 3) == 0);
        bus.AC_LRC  = lrc_r;
        bus.tx_done = auto_tx && (slot_cyc == 12 || (wide && slot_cyc == 13));
        if (auto_refill) begin
            if (q.size() == DEPTH && will_pop()) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = refill_word;
                refill_word = refill_word + 16'd1;
                refill_hits++;
            end else begin
                bus.wr_en = 1'b0;
            end
        end
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        slot_cyc++;
        if (slot_cyc == 16) begin
            slot_cyc = 0;
            lrc_r = ~lrc_r;
        end
    endtask

    task automatic put(input logic [15:0] word);
        bus.wr_en   = 1'b1;
        bus.wr_data = word;
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_pop(input string tag, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            seen = m_last_pop;
        end
        if (!seen) check(tag, 0, 1);
    endtask

    initial begin
        bit done;
        int nvol;
        int pops;
        int hits0;

        bus.AC_LRC    = 1'b0;
        bus.tx_done   = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.vol_shift = '0;
        bus.clr_flags = 1'b0;

        // Reset state
        reset = 1'b1;
        cycle();
        cycle();
        check("rst_dac", bus.dac_data, 16'h0000);
        check("rst_level", bus.level, 0);
        check("rst_playing", bus.playing, 0);
        reset = 1'b0;

        // First pair lands left/right in order
        for (int i = 0; i < 8; i++) put(16'h1111 * (i + 1));
        wait_pop("timeout_first_left", 200);
        check("first_left", bus.dac_data, 16'h1111);
        check("first_playing", bus.playing, 1);
        wait_pop("timeout_first_right", 100);
        check("first_right", bus.dac_data, 16'h2222);

        // Volume shift sampled at pop time, then drain into underrun with one leftover word
        put(16'h8000);
        put(16'h7FF0);
        put(16'h0ABC);
        done = 0;
        nvol = 0;
        for (int i = 0; i < 1500 && !done; i++) begin
            if (q.size() > 0 && q[0] == 16'h8000) bus.vol_shift = 4'd1;
            else if (q.size() > 0 && q[0] == 16'h7FF0) bus.vol_shift = 4'd4;
            else bus.vol_shift = 4'd0;
            cycle();
            if (m_last_pop && m_last_word == 16'h8000) begin
                check("vol1_8000", bus.dac_data, 16'hC000);
                nvol++;
            end
            if (m_last_pop && m_last_word == 16'h7FF0) begin
                check("vol4_7ff0", bus.dac_data, 16'h07FF);
                nvol++;
            end
            if (m_mode == 0) done = 1;
        end
        bus.vol_shift = 4'd0;
        check("vol_seen", nvol, 2);
        check("underrun_reached", done, 1);
        check("ur_dac", bus.dac_data, 16'h0000);
        check("ur_flag", bus.underrun, 1);
        check("ur_playing", bus.playing, 0);
        check("ur_level", bus.level, 1);
        bus.clr_flags = 1'b1;
        cycle();
        bus.clr_flags = 1'b0;
        check("ur_cleared", bus.underrun, 0);

        // Overflow with no pops
        auto_tx = 0;
        for (int i = 0; i < DEPTH; i++) put(16'h5000 + 16'(i));
        check("ovf_full", bus.full, 1);
        check("ovf_level", bus.level, DEPTH);
        check("ovf_flag", bus.overflow, 1);
        bus.clr_flags = 1'b1;
        cycle();
        bus.clr_flags = 1'b0;

        // Write on the same cycle as a pop while full, across pointer wrap
        auto_tx = 1;
        auto_refill = 1;
        pops = 0;
        for (int i = 0; i < 4000 && pops < 140; i++) begin
            hits0 = refill_hits;
            cycle();
            if (m_last_pop) pops++;
            if (refill_hits != hits0) check("full_pop_level", bus.level, DEPTH);
        end
        auto_refill = 0;
        bus.wr_en = 1'b0;
        check("wrap_pops", pops, 140);
        check("full_pop_ovf", bus.overflow, 0);

        // Reset during playback, then refill
        check("pre_reset_playing", bus.playing, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_dac", bus.dac_data, 16'h0000);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_full", bus.full, 0);
        check("mid_rst_playing", bus.playing, 0);
        for (int i = 0; i < 8; i++) put(16'h7100 + 16'(i));
        wait_pop("timeout_refill_left", 200);
        check("refill_left", bus.dac_data, 16'h7100);

        // Random traffic: write rates around the drain rate, wide tx pulses, flag clears, rare resets
        rand_wide = 1;
        for (int i = 0; i < 3000; i++) begin
            bus.wr_en     = (i < 1500) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 19) == 0);
            bus.wr_data   = 16'($urandom);
            bus.vol_shift = 4'($urandom_range(0, 15));
            bus.clr_flags = ($urandom_range(0, 199) == 0);
            reset         = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.clr_flags = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
